// File: rtl/baton_beat_scheduler_if.sv
// Interface bundle between the baton tracker side and the beat scheduler.
// The master drives the control/tracker inputs; the slave (scheduler) drives the beat outputs.
interface baton_beat_scheduler_if #(
    parameter int CNT_W = 26,
    parameter int IDX_W = 3
);
    logic             enable_in;
    logic             frame_valid_in;
    logic             beat_in;
    logic             measure_out;
    logic             beat_strobe_out;
    logic             bar_strobe_out;
    logic [IDX_W-1:0] beat_idx_out;
    logic [CNT_W-1:0] period_out;
    logic             period_valid_out;
    logic             lost_out;
    logic [1:0]       state_out;

    modport master (
        output enable_in, frame_valid_in, beat_in,
        input  measure_out, beat_strobe_out, bar_strobe_out, beat_idx_out,
               period_out, period_valid_out, lost_out, state_out
    );

    modport slave (
        input  enable_in, frame_valid_in, beat_in,
        output measure_out, beat_strobe_out, bar_strobe_out, beat_idx_out,
               period_out, period_valid_out, lost_out, state_out
    );
endinterface

// File: rtl/baton_beat_scheduler.sv
// Turns debounced baton direction-change pulses into a conducted beat: bar position,
// averaged beat period and a lost-beat timeout, plus the tracker's measure strobe.
module baton_beat_scheduler #(
    parameter int CNT_W         = 26,
    parameter int MIN_GAP       = 6_000_000,
    parameter int TIMEOUT_CYC   = 60_000_000,
    parameter int BEATS_PER_BAR = 4,
    parameter int IDX_W         = 3
) (
    input  logic                  clk_camera_in,
    input  logic                  rst_n_in,
    baton_beat_scheduler_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARM   = 2'd1,
        S_TRACK = 2'd2,
        S_LOST  = 2'd3
    } state_e;

    localparam logic [CNT_W-1:0] MIN_GAP_C  = CNT_W'(MIN_GAP);
    localparam logic [CNT_W-1:0] TIMEOUT_LC = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_MAX    = '1;
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(BEATS_PER_BAR - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             first_q, first_d;
    logic             pv_q, pv_d;
    logic             measure_q, measure_d;
    logic             beat_q, beat_d;
    logic             bar_q, bar_d;
    logic             accept;
    logic [CNT_W:0]   period_sum;

    // One extra bit keeps the running average free of overflow.
    assign period_sum = {1'b0, period_q} + {1'b0, cnt_q};

    assign accept = bus.beat_in &&
                    ((state_q == S_ARM) || (state_q == S_LOST) ||
                     ((state_q == S_TRACK) && (cnt_q >= MIN_GAP_C)));

    always_comb begin
        // NOTE: every signal gets a default before any branch so no latch is inferred.
        state_d   = state_q;
        cnt_d     = cnt_q;
        period_d  = period_q;
        idx_d     = idx_q;
        first_d   = first_q;
        pv_d      = pv_q;
        beat_d    = 1'b0;
        bar_d     = 1'b0;
        measure_d = bus.frame_valid_in && (state_q != S_IDLE);

        if (!bus.enable_in) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            idx_d   = '0;
        end else begin
            unique case (state_q)
                S_IDLE: state_d = S_ARM;
                S_ARM, S_LOST: begin
                    if (accept) begin
                        state_d = S_TRACK;
                        cnt_d   = '0;
                        idx_d   = '0;
                        beat_d  = 1'b1;
                        bar_d   = 1'b1;
                        first_d = 1'b1;
                    end
                end
                S_TRACK: begin
                    if (accept) begin
                        cnt_d    = '0;
                        beat_d   = 1'b1;
                        pv_d     = 1'b1;
                        first_d  = 1'b0;
                        period_d = first_q ? cnt_q : period_sum[CNT_W:1];
                        if (idx_q == IDX_LAST) begin
                            idx_d = '0;
                            bar_d = 1'b1;
                        end else begin
                            idx_d = idx_q + 1'b1;
                        end
                    end else if (cnt_q == TIMEOUT_LC) begin
                        // A beat on the timeout cycle takes the branch above instead.
                        state_d = S_LOST;
                        cnt_d   = '0;
                    end else if (cnt_q != CNT_MAX) begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // NOTE: state flops use non-blocking assignments and an async active-low reset.
    always_ff @(posedge clk_camera_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            period_q  <= '0;
            idx_q     <= '0;
            first_q   <= 1'b1;
            pv_q      <= 1'b0;
            measure_q <= 1'b0;
            beat_q    <= 1'b0;
            bar_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            period_q  <= period_d;
            idx_q     <= idx_d;
            first_q   <= first_d;
            pv_q      <= pv_d;
            measure_q <= measure_d;
            beat_q    <= beat_d;
            bar_q     <= bar_d;
        end
    end

    assign bus.measure_out      = measure_q;
    assign bus.beat_strobe_out  = beat_q;
    assign bus.bar_strobe_out   = bar_q;
    assign bus.beat_idx_out     = idx_q;
    assign bus.period_out       = period_q;
    assign bus.period_valid_out = pv_q;
    assign bus.lost_out         = (state_q == S_LOST);
    assign bus.state_out        = state_q;

endmodule

// File: tb/tb_baton_beat_scheduler.sv
// Bench for baton_beat_scheduler: directed scenarios then randomized beats, every cycle
// compared against a cycle-level reference model written from the beat rules.
module tb_baton_beat_scheduler;

    localparam int CNT_W   = 8;
    localparam int IDX_W   = 3;
    localparam int MIN_GAP = 4;
    localparam int TIMEOUT = 20;
    localparam int BPB     = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic clk;
    logic rst_n;
    int   checks   = 0;
    int   failures = 0;

    // Reference model: mode 0..3, cycles counted since the last accepted beat.
    int m_mode, m_gap, m_period, m_idx;
    bit m_pv, m_first, m_bs, m_bar, m_meas;

    baton_beat_scheduler_if #(.CNT_W(CNT_W), .IDX_W(IDX_W)) bus ();

    baton_beat_scheduler #(
        .CNT_W(CNT_W), .MIN_GAP(MIN_GAP), .TIMEOUT_CYC(TIMEOUT),
        .BEATS_PER_BAR(BPB), .IDX_W(IDX_W)
    ) dut (
        .clk_camera_in(clk),
        .rst_n_in     (rst_n),
        .bus          (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_gap = 0; m_period = 0; m_idx = 0;
        m_pv = 0; m_first = 1; m_bs = 0; m_bar = 0; m_meas = 0;
    endtask

    task automatic model_step(input bit en, input bit fv, input bit bt);
        bit acc;
        m_meas = fv && (m_mode != 0);
        m_bs   = 0;
        m_bar  = 0;
        acc = bt && (m_mode == 1 || m_mode == 3 || (m_mode == 2 && m_gap >= MIN_GAP));
        if (!en) begin
            m_mode = 0; m_gap = 0; m_idx = 0;
        end else if (m_mode == 0) begin
            m_mode = 1;
        end else if (acc) begin
            m_bs = 1;
            if (m_mode == 2) begin
                m_period = m_first ? m_gap : (m_period + m_gap) / 2;
                m_first  = 0;
                m_pv     = 1;
                m_idx    = (m_idx + 1) % BPB;
                m_bar    = (m_idx == 0);
            end else begin
                m_idx = 0; m_bar = 1; m_first = 1;
            end
            m_mode = 2;
            m_gap  = 0;
        end else if (m_mode == 2) begin
            if (m_gap == TIMEOUT - 1) begin
                m_mode = 3; m_gap = 0;
            end else begin
                m_gap = (m_gap < CNT_MAX) ? m_gap + 1 : CNT_MAX;
            end
        end
    endtask

    task automatic compare_all();
        check("state",        32'(bus.state_out),        32'(m_mode));
        check("lost",         32'(bus.lost_out),         32'(m_mode == 3));
        check("measure",      32'(bus.measure_out),      32'(m_meas));
        check("beat_strobe",  32'(bus.beat_strobe_out),  32'(m_bs));
        check("bar_strobe",   32'(bus.bar_strobe_out),   32'(m_bar));
        check("beat_idx",     32'(bus.beat_idx_out),     32'(m_idx));
        check("period",       32'(bus.period_out),       32'(m_period));
        check("period_valid", 32'(bus.period_valid_out), 32'(m_pv));
    endtask

    // Drive one cycle of inputs, let the edge take them, then compare #1 later.
    task automatic step(input bit en, input bit fv, input bit bt);
        bus.enable_in      = en;
        bus.frame_valid_in = fv;
        bus.beat_in        = bt;
        @(posedge clk);
        model_step(en, fv, bt);
        #1;
        compare_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_state"},   32'(bus.state_out),        32'd0);
        check({tag, "_period"},  32'(bus.period_out),       32'd0);
        check({tag, "_pv"},      32'(bus.period_valid_out), 32'd0);
        check({tag, "_idx"},     32'(bus.beat_idx_out),     32'd0);
        check({tag, "_lost"},    32'(bus.lost_out),         32'd0);
        check({tag, "_measure"}, 32'(bus.measure_out),      32'd0);
        check({tag, "_beat"},    32'(bus.beat_strobe_out),  32'd0);
        check({tag, "_bar"},     32'(bus.bar_strobe_out),   32'd0);
    endtask

    initial begin
        int beat_mod;
        bus.enable_in      = 1'b0;
        bus.frame_valid_in = 1'b0;
        bus.beat_in        = 1'b0;
        rst_n = 1'b0;
        model_reset();
        #3;
        check_reset_values("reset");
        #9 rst_n = 1'b1;

        // Arm and measure strobe follow-through.
        step(1, 1, 0);
        check("arm_state", 32'(bus.state_out), 32'd1);
        step(1, 1, 0);
        check("measure_follow", 32'(bus.measure_out), 32'd1);
        step(1, 0, 0);
        step(1, 1, 0);

        // First beat, then four more with a counted interval of 10.
        step(1, 0, 1);
        check("first_bar", 32'(bus.bar_strobe_out), 32'd1);
        for (int b = 0; b < 4; b++) begin
            idle(10);
            step(1, 0, 1);
        end
        check("period_10", 32'(bus.period_out), 32'd10);
        check("idx_wrap",  32'(bus.beat_idx_out), 32'd0);
        check("wrap_bar",  32'(bus.bar_strobe_out), 32'd1);

        // Interval 14 averages to 12; a beat 2 cycles later is debounced.
        idle(14);
        step(1, 0, 1);
        check("period_12", 32'(bus.period_out), 32'd12);
        idle(2);
        step(1, 0, 1);
        check("debounce_strobe", 32'(bus.beat_strobe_out), 32'd0);
        check("debounce_period", 32'(bus.period_out), 32'd12);

        // Timeout to LOST, then recovery with a fresh first interval.
        idle(25);
        check("lost_state",  32'(bus.state_out), 32'd3);
        check("lost_period", 32'(bus.period_out), 32'd12);
        step(1, 0, 1);
        check("recover_idx", 32'(bus.beat_idx_out), 32'd0);
        idle(8);
        step(1, 0, 1);
        check("period_8", 32'(bus.period_out), 32'd8);

        // Beat on the timeout cycle wins.
        idle(TIMEOUT - 1);
        step(1, 0, 1);
        check("tie_state", 32'(bus.state_out), 32'd2);
        check("tie_lost",  32'(bus.lost_out), 32'd0);
        check("tie_beat",  32'(bus.beat_strobe_out), 32'd1);

        // Disable mid-TRACK, then an asynchronous reset pulse between edges.
        idle(5);
        step(0, 1, 1);
        check("disable_state", 32'(bus.state_out), 32'd0);
        step(0, 1, 0);
        check("disable_measure", 32'(bus.measure_out), 32'd0);
        check("disable_period",  32'(bus.period_out), 32'd13);
        idle(3);
        step(1, 0, 1);
        idle(6);
        #2 rst_n = 1'b0;
        #1 check_reset_values("async_reset");
        model_reset();
        #1 rst_n = 1'b1;

        // Randomized phase with varying beat density.
        beat_mod = 3;
        for (int i = 0; i < 2000; i++) begin
            bit en, fv, bt;
            if (i % 200 == 0) begin
                case ($urandom_range(0, 2))
                    0:       beat_mod = 3;
                    1:       beat_mod = 9;
                    default: beat_mod = 40;
                endcase
            end
            en = ($urandom_range(0, 149) != 0);
            fv = ($urandom_range(0, 3) == 0);
            bt = ($urandom_range(0, beat_mod - 1) == 0);
            step(en, fv, bt);
            if (i == 1000) begin
                #2 rst_n = 1'b0;
                #1 check_reset_values("rand_reset");
                model_reset();
                #1 rst_n = 1'b1;
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
